// File: rtl/alu_ctrl_decoder.sv
// RV32I ALU-control decoder with a registered output stage and one-entry skid buffer.
// State | meaning: EMPTY nothing held; ONE output register valid; TWO output + skid valid.
module alu_ctrl_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_alu_ctrl,
  output logic        out_is_branch,
  output logic        out_illegal,
  output logic [31:0] out_instr,
  output logic [15:0] illegal_count
);

  localparam logic [5:0] C_ADD  = 6'b011001, C_SUB  = 6'b011011, C_AND  = 6'b011101,
                         C_OR   = 6'b011111, C_XOR  = 6'b100001, C_SLT  = 6'b100011,
                         C_SLTU = 6'b100101, C_SLL  = 6'b100111, C_SRL  = 6'b101001,
                         C_SRA  = 6'b101011, C_BEQ  = 6'b101101, C_BNE  = 6'b101111,
                         C_BGE  = 6'b110001, C_BLT  = 6'b110011, C_BGEU = 6'b110101,
                         C_BLTU = 6'b110111;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t      r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [5:0]  r_out_ctrl,  r_skid_ctrl;
  logic        r_out_br,    r_skid_br;
  logic        r_out_ill,   r_skid_ill;
  logic [31:0] r_out_instr, r_skid_instr;
  logic [15:0] r_ill_cnt;

  logic [5:0]  w_ctrl;
  logic        w_br;
  logic        w_ill;
  logic        w_accept;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;

  assign w_op     = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];
  assign w_accept = in_valid & r_in_ready;

  always_comb begin
    w_ctrl = C_ADD;
    w_br   = 1'b0;
    w_ill  = 1'b0;
    case (w_op)
      7'b0110011: begin
        case (w_f3)
          3'b000: if (w_f7 == 7'b0000000) w_ctrl = C_ADD;
                  else if (w_f7 == 7'b0100000) w_ctrl = C_SUB;
                  else w_ill = 1'b1;
          3'b101: if (w_f7 == 7'b0000000) w_ctrl = C_SRL;
                  else if (w_f7 == 7'b0100000) w_ctrl = C_SRA;
                  else w_ill = 1'b1;
          default: begin
            if (w_f7 != 7'b0000000) w_ill = 1'b1;
            case (w_f3)
              3'b001:  w_ctrl = C_SLL;
              3'b010:  w_ctrl = C_SLT;
              3'b011:  w_ctrl = C_SLTU;
              3'b100:  w_ctrl = C_XOR;
              3'b110:  w_ctrl = C_OR;
              default: w_ctrl = C_AND;
            endcase
          end
        endcase
      end
      7'b0010011: begin
        case (w_f3)
          3'b000: w_ctrl = C_ADD;
          3'b010: w_ctrl = C_SLT;
          3'b011: w_ctrl = C_SLTU;
          3'b100: w_ctrl = C_XOR;
          3'b110: w_ctrl = C_OR;
          3'b111: w_ctrl = C_AND;
          3'b001: if (w_f7 == 7'b0000000) w_ctrl = C_SLL;
                  else w_ill = 1'b1;
          default: if (w_f7 == 7'b0000000) w_ctrl = C_SRL;
                   else if (w_f7 == 7'b0100000) w_ctrl = C_SRA;
                   else w_ill = 1'b1;
        endcase
      end
      7'b1100011: begin
        w_br = 1'b1;
        case (w_f3)
          3'b000: w_ctrl = C_BEQ;
          3'b001: w_ctrl = C_BNE;
          3'b100: w_ctrl = C_BLT;
          3'b101: w_ctrl = C_BGE;
          3'b110: w_ctrl = C_BLTU;
          3'b111: w_ctrl = C_BGEU;
          default: begin
            w_br  = 1'b0;
            w_ill = 1'b1;
          end
        endcase
      end
      7'b0000011, 7'b0100011, 7'b1100111,
      7'b1101111, 7'b0110111, 7'b0010111: w_ctrl = C_ADD;
      default: w_ill = 1'b1;
    endcase
    // illegal words always present as a plain ADD
    if (w_ill) begin
      w_ctrl = C_ADD;
      w_br   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= EMPTY;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_ctrl   <= C_ADD;
      r_out_br     <= 1'b0;
      r_out_ill    <= 1'b0;
      r_out_instr  <= 32'd0;
      r_skid_ctrl  <= C_ADD;
      r_skid_br    <= 1'b0;
      r_skid_ill   <= 1'b0;
      r_skid_instr <= 32'd0;
      r_ill_cnt    <= 16'd0;
    end else begin
      r_in_ready <= 1'b1;
      if (w_accept && w_ill && r_ill_cnt != 16'hFFFF)
        r_ill_cnt <= r_ill_cnt + 16'd1;
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_out_ctrl  <= w_ctrl;
            r_out_br    <= w_br;
            r_out_ill   <= w_ill;
            r_out_instr <= in_instr;
            r_out_valid <= 1'b1;
            r_state     <= ONE;
          end
        end
        ONE: begin
          if (w_accept && out_ready) begin
            r_out_ctrl  <= w_ctrl;
            r_out_br    <= w_br;
            r_out_ill   <= w_ill;
            r_out_instr <= in_instr;
          end else if (w_accept) begin
            r_skid_ctrl  <= w_ctrl;
            r_skid_br    <= w_br;
            r_skid_ill   <= w_ill;
            r_skid_instr <= in_instr;
            r_in_ready   <= 1'b0;
            r_state      <= TWO;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= EMPTY;
          end
        end
        TWO: begin
          if (out_ready) begin
            r_out_ctrl  <= r_skid_ctrl;
            r_out_br    <= r_skid_br;
            r_out_ill   <= r_skid_ill;
            r_out_instr <= r_skid_instr;
            r_state     <= ONE;
          end else begin
            r_in_ready <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= EMPTY;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_alu_ctrl  = r_out_ctrl;
  assign out_is_branch = r_out_br;
  assign out_illegal   = r_out_ill;
  assign out_instr     = r_out_instr;
  assign illegal_count = r_ill_cnt;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Bench for alu_ctrl_decoder: directed scenarios plus random valid/ready traffic
// checked against a table-driven decode model and an ordered expectation queue.
module tb_alu_ctrl_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_alu_ctrl;
  logic        out_is_branch;
  logic        out_illegal;
  logic [31:0] out_instr;
  logic [15:0] illegal_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [5:0]  ctrl;
    logic        br;
    logic        ill;
    logic [31:0] instr;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_cnt = 16'd0;

  // ALU codes by funct3 of the arithmetic group: ADD SLL SLT SLTU XOR SRL OR AND
  localparam int R_TAB [8] = '{25, 39, 35, 37, 33, 41, 31, 29};
  // branch codes by funct3: BEQ BNE - - BLT BGE BLTU BGEU
  localparam int B_TAB [8] = '{45, 47, -1, -1, 51, 49, 55, 53};
  localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23,
                                      7'h67, 7'h6F, 7'h37, 7'h17, 7'h0B};

  always #5 clk = ~clk;

  alu_ctrl_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctrl(out_alu_ctrl), .out_is_branch(out_is_branch),
    .out_illegal(out_illegal), .out_instr(out_instr), .illegal_count(illegal_count)
  );

  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e;
    int   op, f3, f7;
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    e.ctrl = 6'd25; e.br = 1'b0; e.ill = 1'b1; e.instr = w;
    if (op == 'h33 || (op == 'h13 && (f3 == 1 || f3 == 5))) begin
      if (f7 == 0) begin
        e.ctrl = 6'(R_TAB[f3]); e.ill = 1'b0;
      end else if (f7 == 'h20 && (f3 == 5 || (f3 == 0 && op == 'h33))) begin
        e.ctrl = 6'(R_TAB[f3] + 2); e.ill = 1'b0;
      end
    end else if (op == 'h13) begin
      e.ctrl = 6'(R_TAB[f3]); e.ill = 1'b0;
    end else if (op == 'h63) begin
      if (B_TAB[f3] >= 0) begin
        e.ctrl = 6'(B_TAB[f3]); e.br = 1'b1; e.ill = 1'b0;
      end
    end else if (op == 'h03 || op == 'h23 || op == 'h67 || op == 'h6F ||
                 op == 'h37 || op == 'h17) begin
      e.ill = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] op, f7;
    int         k;
    k  = $urandom_range(0, 10);
    op = (k == 10) ? 7'($urandom) : OPS[k];
    case ($urandom_range(0, 3))
      0, 3:    f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 10'($urandom), 3'($urandom), 5'($urandom), op};
  endfunction

  // one clock of stimulus; checks everything observable after the previous edge
  task automatic cycle(input logic v, input logic [31:0] w, input logic rdy);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_instr = w; out_ready = rdy;
    #1;
    total++;
    if (in_ready !== (q.size() < 2)) begin
      bad++; $display("FAIL in_ready: got %b want %b", in_ready, q.size() < 2);
    end
    total++;
    if (out_valid !== (q.size() > 0)) begin
      bad++; $display("FAIL out_valid: got %b want %b", out_valid, q.size() > 0);
    end
    total++;
    if (illegal_count !== m_cnt) begin
      bad++; $display("FAIL illegal_count: got %h want %h", illegal_count, m_cnt);
    end
    if (out_valid === 1'b1 && out_ready && q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (out_alu_ctrl !== e.ctrl || out_is_branch !== e.br ||
          out_illegal !== e.ill || out_instr !== e.instr) begin
        bad++;
        $display("FAIL out_word: got ctrl=%b br=%b ill=%b instr=%h want ctrl=%b br=%b ill=%b instr=%h",
                 out_alu_ctrl, out_is_branch, out_illegal, out_instr, e.ctrl, e.br, e.ill, e.instr);
      end
    end
    if (in_valid && in_ready === 1'b1) begin
      e = ref_dec(w);
      q.push_back(e);
      if (e.ill && m_cnt != 16'hFFFF) m_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || illegal_count !== 16'd0 ||
        out_alu_ctrl !== 6'b011001 || out_is_branch !== 1'b0 ||
        out_illegal !== 1'b0 || out_instr !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%b rdy=%b cnt=%h ctrl=%b br=%b ill=%b instr=%h want 0 0 0 011001 0 0 0",
               out_valid, in_ready, illegal_count, out_alu_ctrl, out_is_branch, out_illegal, out_instr);
    end
    q.delete();
    m_cnt = 16'd0;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    cycle(1'b0, 32'd0, 1'b0);
  endtask

  task automatic test_add();
    cycle(1'b1, 32'h003100B3, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || out_alu_ctrl !== 6'b011001 || out_illegal !== 1'b0) begin
      bad++; $display("FAIL add_latency: got v=%b ctrl=%b ill=%b want 1 011001 0",
                      out_valid, out_alu_ctrl, out_illegal);
    end
    cycle(1'b0, 32'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 32'h403100B3, 1'b1);
    cycle(1'b1, 32'h4020D093, 1'b1);
    total++;
    if (out_alu_ctrl !== 6'b011011) begin
      bad++; $display("FAIL b2b_sub: got %b want 011011", out_alu_ctrl);
    end
    cycle(1'b1, 32'h0020E463, 1'b1);
    total++;
    if (out_alu_ctrl !== 6'b101011) begin
      bad++; $display("FAIL b2b_srai: got %b want 101011", out_alu_ctrl);
    end
    cycle(1'b0, 32'd0, 1'b1);
    total++;
    if (out_alu_ctrl !== 6'b110111 || out_is_branch !== 1'b1) begin
      bad++; $display("FAIL b2b_bltu: got %b br=%b want 110111 1", out_alu_ctrl, out_is_branch);
    end
    cycle(1'b0, 32'd0, 1'b1);
  endtask

  task automatic test_skid();
    cycle(1'b1, 32'h003100B3, 1'b0);
    cycle(1'b1, 32'h403100B3, 1'b0);
    cycle(1'b1, 32'h0020E463, 1'b0);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL skid_full_ready: got %b want 0", in_ready);
    end
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL skid_drained: got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    cycle(1'b1, 32'h0000000B, 1'b1);
    cycle(1'b1, 32'h40001013, 1'b1);
    total++;
    if (out_illegal !== 1'b1 || out_alu_ctrl !== 6'b011001) begin
      bad++; $display("FAIL illegal_custom: got ill=%b ctrl=%b want 1 011001", out_illegal, out_alu_ctrl);
    end
    cycle(1'b0, 32'd0, 1'b1);
    total++;
    if (illegal_count !== 16'd2 || out_illegal !== 1'b1) begin
      bad++; $display("FAIL illegal_two: got cnt=%0d ill=%b want 2 1", illegal_count, out_illegal);
    end
    for (int i = 0; i < 65537; i++) cycle(1'b1, 32'h0000000B, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    total++;
    if (illegal_count !== 16'hFFFF) begin
      bad++; $display("FAIL illegal_saturate: got %h want ffff", illegal_count);
    end
  endtask

  task automatic test_reset_in_two();
    cycle(1'b1, 32'h0000000B, 1'b0);
    cycle(1'b1, 32'h003100B3, 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    total++;
    if (in_ready !== 1'b0 || illegal_count === 16'd0) begin
      bad++; $display("FAIL pre_reset_two: got rdy=%b cnt=%h want 0 nonzero", in_ready, illegal_count);
    end
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1);
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 2) != 0));
    n = 0;
    while (q.size() > 0 && n < 10) begin
      cycle(1'b0, 32'd0, 1'b1);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL random_drain: got %0d words left want 0", q.size());
    end
    cycle(1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_skid();
    test_random();
    test_reset_in_two();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_decoder.md
ALU_CTRL_DECODER -- requirements
Module: alu_ctrl_decoder

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_valid  in  1  instruction offered; in_instr  in  32  RV32I instruction word; in_ready  out  1  decoder accepts this cycle.
REQ-004 SHALL have ports: out_valid  out  1  decoded result held; out_ready  in  1  consumer accepts; out_alu_ctrl  out  6  ALU control code; out_is_branch  out  1  branch compare op; out_illegal  out  1  unsupported encoding; out_instr  out  32  accepted word, passed through.
REQ-005 SHALL have port: illegal_count  out  16  saturating count of illegal words accepted.

Function
REQ-006 SHALL emit codes: ADD 011001, SUB 011011, AND 011101, OR 011111, XOR 100001, SLT 100011, SLTU 100101, SLL 100111, SRL 101001, SRA 101011, BEQ 101101, BNE 101111, BGE 110001, BLT 110011, BGEU 110101, BLTU 110111.
REQ-007 SHALL decode opcode 0110011 (R) by funct3: 000 ADD (f7=0000000) / SUB (f7=0100000); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL (f7=0000000) / SRA (f7=0100000); 110 OR; 111 AND; any other funct7 -> illegal.
REQ-008 SHALL decode opcode 0010011 (I) by funct3: 000 ADD; 010 SLT; 011 SLTU; 100 XOR; 110 OR; 111 AND; 001 SLL only if instr[31:25]=0000000; 101 SRL/SRA per instr[31:25] as R-type; else illegal.
REQ-009 SHALL decode opcode 1100011 by funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU, with out_is_branch=1; funct3 010/011 -> illegal.
REQ-010 SHALL map opcodes 0000011, 0100011, 1100111, 1101111, 0110111, 0010111 to ADD, out_is_branch=0.
REQ-011 SHALL, for any illegal word (incl. instr[1:0]!=11 or unlisted opcode), output out_alu_ctrl=ADD, out_is_branch=0, out_illegal=1.
REQ-012 SHALL register all outputs; latency accept-to-out_valid exactly 1 cycle; no combinational path from in_* to out_* or from out_ready to in_ready.
REQ-013 SHALL implement output register plus one-entry skid register; FSM states EMPTY (none held), ONE (output valid), TWO (output + skid valid).
REQ-014 SHALL drive in_ready=1 in EMPTY and ONE, 0 in TWO (registered).
REQ-015 Transitions: EMPTY+accept->ONE; ONE+accept+out_ready->ONE (new word replaces); ONE+accept+!out_ready->TWO (new word to skid); ONE+!accept+out_ready->EMPTY; TWO+out_ready->ONE (skid moves to output); otherwise hold.
REQ-016 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-017 SHALL preserve acceptance order; no word dropped or duplicated.
REQ-018 SHALL increment illegal_count on each accepted illegal word, saturating at 0xFFFF.
REQ-019 SHALL decode at acceptance; in_instr ignored when in_valid=0 or in_ready=0.

Reset
REQ-020 SHALL on rst_n=0 immediately enter EMPTY: out_valid=0, out_alu_ctrl=011001, out_is_branch=0, out_illegal=0, out_instr=0, illegal_count=0, in_ready=0 while asserted.
REQ-021 SHALL raise in_ready=1 on first clk edge after rst_n deasserts; reset mid-transfer discards held words.

Verification
REQ-022 add x1,x2,x3 (0x003100B3) with out_ready=1 -> next cycle out_valid=1, out_alu_ctrl=011001, out_illegal=0.
REQ-023 sub 0x403100B3, srai 0x4020D093, bltu 0x0020E463 back-to-back, out_ready=1 -> 011011, 101011, 110111 (is_branch=1) on consecutive cycles.
REQ-024 out_ready=0, offer two words -> second lands in skid, in_ready=0; third word held off; out_ready=1 -> both emitted in order, in_ready returns 1.
REQ-025 0x0000000B and slli with instr[31:25]=0100000 -> out_illegal=1, out_alu_ctrl=011001, illegal_count=2; 65537 illegal words -> count 0xFFFF.
REQ-026 rst_n low while in TWO -> out_valid=0 and illegal_count=0 asynchronously; after release no stale word emitted.
REQ-027 Random valid/ready stalls over all encodings vs. reference model -> identical ordered output stream.
